spi_req_arbiter: RTL and testbench

//  Shares one SPI master between NUM_REQ requesters. Round-robin arbitration.
//  Per-transfer config latched at grant: byte, CPOL, CPHA, clock divider.

---
 rtl/spi_req_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_spi_req_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_req_arbiter.sv
// Round-robin arbiter that shares one SPI master between NUM_REQ requesters.
// Latches per-transfer config at grant and sequences CS setup, launch, completion wait and CS hold.
module spi_req_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int SETUP_CYC   = 2,
  parameter int HOLD_CYC    = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NUM_REQ-1:0]   REQ,
  input  logic [8*NUM_REQ-1:0] REQ_DATA,
  input  logic [NUM_REQ-1:0]   REQ_CPOL,
  input  logic [NUM_REQ-1:0]   REQ_CPHA,
  input  logic [3*NUM_REQ-1:0] REQ_DIV,
  input  logic                 SPI_XFER_DONE,
  output logic [7:0]           SPI_DATA,
  output logic                 SPI_DATA_VALID,
  output logic                 SPI_CPOL,
  output logic                 SPI_CPHA,
  output logic [2:0]           SPI_DIV,
  output logic [NUM_REQ-1:0]   CS_N,
  output logic [NUM_REQ-1:0]   ACK,
  output logic [NUM_REQ-1:0]   ERR,
  output logic                 BUSY
);

  localparam int IDX_W   = $clog2(NUM_REQ);
  localparam int MAX_SH  = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
  localparam int CNT_MAX = (TIMEOUT_CYC > MAX_SH) ? TIMEOUT_CYC : MAX_SH;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    LAUNCH,
    WAIT_DONE,
    HOLD
  } state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [IDX_W-1:0]   grant_reg, grant_next;
  logic [IDX_W-1:0]   ptr_reg, ptr_next;
  logic               ok_reg, ok_next;
  logic [7:0]         data_reg, data_next;
  logic               cpol_reg, cpol_next;
  logic               cpha_reg, cpha_next;
  logic [2:0]         div_reg, div_next;
  logic [NUM_REQ-1:0] cs_n_reg, cs_n_next;
  logic [NUM_REQ-1:0] ack_reg, ack_next;
  logic [NUM_REQ-1:0] err_reg, err_next;
  logic               dv_reg, dv_next;
  logic               busy_reg, busy_next;

  logic [7:0]         req_data_arr [NUM_REQ];
  logic [2:0]         req_div_arr  [NUM_REQ];

  logic               found;
  logic [IDX_W-1:0]   found_idx;
  logic [IDX_W-1:0]   cand_idx;
  int                 cand;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
    assign req_data_arr[gi] = REQ_DATA[8*gi +: 8];
    assign req_div_arr[gi]  = REQ_DIV[3*gi +: 3];
  end

  // Rotating priority search: first requester at or above the pointer, wrapping.
  always_comb begin
    found     = 1'b0;
    found_idx = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = int'(ptr_reg) + off;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!found && REQ[cand_idx]) begin
        found     = 1'b1;
        found_idx = cand_idx;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    grant_next = grant_reg;
    ptr_next   = ptr_reg;
    ok_next    = ok_reg;
    data_next  = data_reg;
    cpol_next  = cpol_reg;
    cpha_next  = cpha_reg;
    div_next   = div_reg;
    case (state_reg)
      IDLE: begin
        if (found) begin
          grant_next = found_idx;
          data_next  = req_data_arr[found_idx];
          cpol_next  = REQ_CPOL[found_idx];
          cpha_next  = REQ_CPHA[found_idx];
          div_next   = req_div_arr[found_idx];
          cnt_next   = '0;
          state_next = SETUP;
        end
      end
      SETUP: begin
        if (cnt_reg == CNT_W'(SETUP_CYC - 1)) begin
          cnt_next   = '0;
          state_next = LAUNCH;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      LAUNCH: begin
        cnt_next   = '0;
        state_next = WAIT_DONE;
      end
      WAIT_DONE: begin
        // A done pulse in the final counted cycle still counts as success.
        if (SPI_XFER_DONE) begin
          ok_next    = 1'b1;
          cnt_next   = '0;
          state_next = HOLD;
        end else if (cnt_reg == CNT_W'(TIMEOUT_CYC - 1)) begin
          ok_next    = 1'b0;
          cnt_next   = '0;
          state_next = HOLD;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      HOLD: begin
        if (cnt_reg == CNT_W'(HOLD_CYC - 1)) begin
          cnt_next   = '0;
          ptr_next   = (grant_reg == IDX_W'(NUM_REQ - 1)) ? '0 : grant_reg + 1'b1;
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered copies of what the next state implies.
  always_comb begin
    cs_n_next = '1;
    ack_next  = '0;
    err_next  = '0;
    dv_next   = (state_next == LAUNCH);
    busy_next = (state_next != IDLE);
    if (state_next != IDLE) cs_n_next[grant_next] = 1'b0;
    if (state_next == HOLD && cnt_next == CNT_W'(HOLD_CYC - 1)) begin
      ack_next[grant_next] = ok_next;
      err_next[grant_next] = ~ok_next;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      grant_reg <= '0;
      ptr_reg   <= '0;
      ok_reg    <= 1'b0;
      data_reg  <= '0;
      cpol_reg  <= 1'b0;
      cpha_reg  <= 1'b0;
      div_reg   <= '0;
      cs_n_reg  <= '1;
      ack_reg   <= '0;
      err_reg   <= '0;
      dv_reg    <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      grant_reg <= grant_next;
      ptr_reg   <= ptr_next;
      ok_reg    <= ok_next;
      data_reg  <= data_next;
      cpol_reg  <= cpol_next;
      cpha_reg  <= cpha_next;
      div_reg   <= div_next;
      cs_n_reg  <= cs_n_next;
      ack_reg   <= ack_next;
      err_reg   <= err_next;
      dv_reg    <= dv_next;
      busy_reg  <= busy_next;
    end
  end

  assign SPI_DATA       = data_reg;
  assign SPI_DATA_VALID = dv_reg;
  assign SPI_CPOL       = cpol_reg;
  assign SPI_CPHA       = cpha_reg;
  assign SPI_DIV        = div_reg;
  assign CS_N           = cs_n_reg;
  assign ACK            = ack_reg;
  assign ERR            = err_reg;
  assign BUSY           = busy_reg;

endmodule

// File: tb/tb_spi_req_arbiter.sv
// Directed bench for spi_req_arbiter: single transfer, round-robin order, timeout,
// config freeze, reset mid-transfer, stray and coincident done pulses.
module tb_spi_req_arbiter;
  localparam int N = 4;

  logic           CLK = 1'b0;
  logic           RST;
  logic [N-1:0]   REQ;
  logic [8*N-1:0] REQ_DATA;
  logic [N-1:0]   REQ_CPOL;
  logic [N-1:0]   REQ_CPHA;
  logic [3*N-1:0] REQ_DIV;
  logic           SPI_XFER_DONE;
  logic [7:0]     SPI_DATA;
  logic           SPI_DATA_VALID;
  logic           SPI_CPOL;
  logic           SPI_CPHA;
  logic [2:0]     SPI_DIV;
  logic [N-1:0]   CS_N;
  logic [N-1:0]   ACK;
  logic [N-1:0]   ERR;
  logic           BUSY;

  int tests   = 0;
  int fails   = 0;
  int mon_bad = 0;

  spi_req_arbiter #(
    .NUM_REQ(N), .SETUP_CYC(2), .HOLD_CYC(2), .TIMEOUT_CYC(16)
  ) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .REQ_DATA(REQ_DATA), .REQ_CPOL(REQ_CPOL),
    .REQ_CPHA(REQ_CPHA), .REQ_DIV(REQ_DIV), .SPI_XFER_DONE(SPI_XFER_DONE),
    .SPI_DATA(SPI_DATA), .SPI_DATA_VALID(SPI_DATA_VALID), .SPI_CPOL(SPI_CPOL),
    .SPI_CPHA(SPI_CPHA), .SPI_DIV(SPI_DIV), .CS_N(CS_N), .ACK(ACK), .ERR(ERR),
    .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  // Structural invariants sampled on the falling edge.
  always @(negedge CLK) begin
    if (RST === 1'b1) begin
      if ($countones(~CS_N) > 1 || (ACK & ERR) != '0 ||
          $countones(ACK) > 1 || $countones(ERR) > 1)
        mon_bad <= mon_bad + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_dv(input string tag);
    int n = 0;
    while (SPI_DATA_VALID !== 1'b1 && n < 64) begin
      tick();
      n++;
    end
    chk({tag, "_dv_seen"}, {31'd0, SPI_DATA_VALID}, 32'd1);
  endtask

  task automatic set_cfg(input int i, input logic [7:0] d, input logic pol,
                         input logic pha, input logic [2:0] dv);
    REQ_DATA[8*i +: 8] = d;
    REQ_CPOL[i]        = pol;
    REQ_CPHA[i]        = pha;
    REQ_DIV[3*i +: 3]  = dv;
  endtask

  task automatic pulse_done();
    SPI_XFER_DONE = 1'b1;
    tick();
    SPI_XFER_DONE = 1'b0;
  endtask

  initial begin
    logic [N-1:0] oh;
    logic [N-1:0] exp_cs;
    logic [7:0]   exp_data;

    RST = 1'b0; REQ = '0; REQ_DATA = '0; REQ_CPOL = '0; REQ_CPHA = '0;
    REQ_DIV = '0; SPI_XFER_DONE = 1'b0;

    // Reset state
    #12;
    chk("rst_cs_n", 32'(CS_N), 32'hF);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_ack_err", 32'({ACK, ERR}), 32'd0);
    chk("rst_dv", 32'(SPI_DATA_VALID), 32'd0);
    chk("rst_cfg", 32'({SPI_DATA, SPI_CPOL, SPI_CPHA, SPI_DIV}), 32'd0);
    tick();
    RST = 1'b1;
    tick(); tick();
    chk("idle_busy", 32'(BUSY), 32'd0);

    // 1: single request
    set_cfg(1, 8'hA5, 1'b1, 1'b0, 3'd5);
    REQ = 4'b0010;
    tick();
    chk("t1_cs_n", 32'(CS_N), 32'hD);
    chk("t1_data", 32'(SPI_DATA), 32'hA5);
    chk("t1_cpol_cpha_div", 32'({SPI_CPOL, SPI_CPHA, SPI_DIV}), 32'b10101);
    chk("t1_busy", 32'(BUSY), 32'd1);
    chk("t1_dv_c1", 32'(SPI_DATA_VALID), 32'd0);
    tick();
    chk("t1_dv_c2", 32'(SPI_DATA_VALID), 32'd0);
    tick();
    chk("t1_dv_c3", 32'(SPI_DATA_VALID), 32'd1);
    tick();
    chk("t1_dv_c4", 32'(SPI_DATA_VALID), 32'd0);
    pulse_done();
    chk("t1_ack_early", 32'(ACK), 32'd0);
    tick();
    chk("t1_ack", 32'(ACK), 32'h2);
    chk("t1_err", 32'(ERR), 32'd0);
    chk("t1_cs_hold", 32'(CS_N), 32'hD);
    REQ = '0;
    tick();
    chk("t1_cs_release", 32'(CS_N), 32'hF);
    chk("t1_ack_done", 32'(ACK), 32'd0);
    chk("t1_busy_idle", 32'(BUSY), 32'd0);

    // 2: round-robin with all requests held, pointer reset to 0
    RST = 1'b0; #2; RST = 1'b1;
    tick();
    for (int i = 0; i < N; i++) set_cfg(i, 8'(8'h10 + i), 1'b0, 1'b0, 3'(i));
    REQ = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      oh       = 4'b0001 << (k % N);
      exp_cs   = ~oh;
      exp_data = 8'(8'h10 + (k % N));
      wait_dv($sformatf("t2_%0d", k));
      chk($sformatf("t2_%0d_cs_n", k), 32'(CS_N), 32'(exp_cs));
      chk($sformatf("t2_%0d_data", k), 32'(SPI_DATA), 32'(exp_data));
      repeat (5) tick();
      pulse_done();
      tick();
      chk($sformatf("t2_%0d_ack", k), 32'(ACK), 32'(oh));
      tick();
      chk($sformatf("t2_%0d_gap", k), 32'({BUSY, CS_N}), 32'h0F);
    end
    REQ = '0;
    tick();

    // 3: timeout on requester 2, then a normal transfer
    set_cfg(2, 8'h5A, 1'b0, 1'b1, 3'd1);
    REQ = 4'b0100;
    wait_dv("t3");
    repeat (16) tick();
    chk("t3_no_err_yet", 32'({ERR, CS_N}), 32'h0B);
    tick();
    chk("t3_hold_no_err", 32'(ERR), 32'd0);
    tick();
    chk("t3_err", 32'(ERR), 32'h4);
    chk("t3_no_ack", 32'(ACK), 32'd0);
    REQ = '0;
    tick();
    chk("t3_release", 32'({BUSY, CS_N, ERR}), 32'h0F0);
    REQ = 4'b0001;
    wait_dv("t3_next");
    chk("t3_next_cs_n", 32'(CS_N), 32'hE);
    tick(); tick();
    pulse_done();
    tick();
    chk("t3_next_ack", 32'(ACK), 32'h1);
    REQ = '0;
    tick(); tick();

    // 4: config frozen while WAIT_DONE
    set_cfg(3, 8'h3C, 1'b0, 1'b1, 3'd2);
    REQ = 4'b1000;
    wait_dv("t4");
    tick(); tick();
    set_cfg(3, 8'hFF, 1'b1, 1'b0, 3'd7);
    tick();
    chk("t4_frozen", 32'({SPI_DATA, SPI_CPOL, SPI_CPHA, SPI_DIV}), 32'({8'h3C, 1'b0, 1'b1, 3'd2}));
    pulse_done();
    tick();
    chk("t4_ack", 32'(ACK), 32'h8);
    chk("t4_still_frozen", 32'({SPI_DATA, SPI_CPOL, SPI_DIV}), 32'({8'h3C, 1'b0, 3'd2}));
    REQ = '0;
    tick(); tick();
    REQ = 4'b1000;
    tick();
    chk("t4_new_cfg", 32'({SPI_DATA, SPI_CPOL, SPI_CPHA, SPI_DIV}), 32'({8'hFF, 1'b1, 1'b0, 3'd7}));
    wait_dv("t4b");
    tick();
    pulse_done();
    tick();
    chk("t4b_ack", 32'(ACK), 32'h8);
    REQ = '0;
    tick(); tick();

    // 6: stray done in IDLE and in LAUNCH, done coincident with timeout
    pulse_done();
    chk("t6_idle_stray", 32'({BUSY, CS_N, ACK, ERR}), 32'h0F00);
    tick();
    chk("t6_idle_stray_ack", 32'({ACK, ERR}), 32'd0);
    REQ = 4'b0100;
    wait_dv("t6");
    pulse_done();
    repeat (15) tick();
    chk("t6_launch_stray_ignored", 32'({BUSY, ERR, ACK}), 32'h100);
    pulse_done();
    tick();
    chk("t6_coincident_ack", 32'(ACK), 32'h4);
    chk("t6_coincident_err", 32'(ERR), 32'd0);
    REQ = '0;
    tick();
    chk("t6_idle", 32'(BUSY), 32'd0);

    // 5: reset during WAIT_DONE
    REQ = 4'b0100;
    wait_dv("t5");
    tick(); tick();
    RST = 1'b0;
    #1;
    chk("t5_rst_cs_busy", 32'({BUSY, CS_N}), 32'h0F);
    chk("t5_rst_outs", 32'({ACK, ERR, SPI_DATA_VALID, SPI_DATA}), 32'd0);
    REQ = '0;
    tick(); tick();
    RST = 1'b1;
    tick();
    chk("t5_no_ack_err", 32'({ACK, ERR, BUSY}), 32'd0);
    REQ = 4'b1010;
    tick();
    chk("t5_ptr0_grant1", 32'(CS_N), 32'hD);
    wait_dv("t5a");
    tick();
    pulse_done();
    tick();
    chk("t5a_ack", 32'(ACK), 32'h2);
    REQ = '0;
    tick(); tick();
    RST = 1'b0; #2; RST = 1'b1;
    tick();
    REQ = 4'b1000;
    tick();
    chk("t5_req3_grant", 32'(CS_N), 32'h7);
    wait_dv("t5b");
    tick();
    pulse_done();
    tick();
    chk("t5b_ack", 32'(ACK), 32'h8);
    REQ = '0;
    tick(); tick();

    chk("monitor_invariants", 32'(mon_bad), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
